// File: rtl/pn_burst_arbiter.sv
// rtl/pn_burst_arbiter.sv - round-robin burst arbiter sharing one PN (LFSR) generator between two requesters
//
// Purpose: grants bursts of pseudo-noise bits to two requesters in round-robin
// order and streams one bit per accepted transfer, tagged with the owner ID.
//
// Optional feature macro: PN_RESEED_EN
//   defined   - the LFSR is reloaded with SEED at every grant with nonzero length
//   undefined - the LFSR continues across bursts from the last accepted bit
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   req[1:0]  per-requester request level, dropped on seeing its gnt bit
//   len0/len1 burst length in bits, sampled at grant
//   gnt[1:0]  one-hot, one-cycle grant pulse
//   pn_bit    current PN bit (lfsr[0])
//   pn_valid  pn_bit is valid
//   pn_ready  consumer accepts pn_bit
//   pn_last   current bit is the final bit of the burst
//   pn_id     owner of the current burst
//   busy      a burst is in progress
module pn_burst_arbiter #(
    parameter int                LFSR_W = 3,
    parameter logic [LFSR_W-1:0] TAPS   = 3'b101,
    parameter logic [LFSR_W-1:0] SEED   = {LFSR_W{1'b1}},
    parameter int                LEN_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic             pn_bit,
    output logic             pn_valid,
    input  logic             pn_ready,
    output logic             pn_last,
    output logic             pn_id,
    output logic             busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        state;
    logic [LFSR_W-1:0] lfsr;
    logic [LEN_W-1:0]  cnt;
    logic              rr;
    logic              winner;
    logic [LEN_W-1:0]  win_len;
    logic              fb;

    // With both requests pending the pointer decides; otherwise the lone
    // requester wins (req[1] is 1 exactly when requester 1 is alone).
    assign winner  = (req == 2'b11) ? rr : req[1];
    assign win_len = winner ? len1 : len0;
    assign fb      = ^(lfsr & TAPS);

    // The state register itself drives valid/busy, so no output depends
    // combinationally on pn_ready.
    assign pn_valid = (state == S_RUN);
    assign busy     = (state == S_RUN);
    assign pn_bit   = lfsr[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            lfsr    <= SEED;
            cnt     <= '0;
            gnt     <= 2'b00;
            pn_last <= 1'b0;
            pn_id   <= 1'b0;
            rr      <= 1'b0;
        end else begin
            gnt <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        gnt   <= winner ? 2'b10 : 2'b01;
                        pn_id <= winner;
                        cnt   <= win_len;
                        rr    <= ~winner;
                        // A zero-length grant only pulses gnt; no data, LFSR untouched.
                        if (win_len != '0) begin
                            state   <= S_RUN;
                            pn_last <= (win_len == LEN_W'(1));
`ifdef PN_RESEED_EN
                            lfsr    <= SEED;
`endif
                        end
                    end
                end
                default: begin
                    if (pn_ready) begin
                        lfsr    <= {fb, lfsr[LFSR_W-1:1]};
                        cnt     <= cnt - LEN_W'(1);
                        // Next bit is the last one when two bits remain now.
                        pn_last <= (cnt == LEN_W'(2));
                        if (pn_last) begin
                            state   <= S_IDLE;
                            pn_last <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/pn_burst_arbiter.md
# pn_burst_arbiter

Shares one PN (LFSR) generator between two requesters. Each requester asks for a burst of pseudo-noise bits, and bursts are granted round-robin. Each burst streams one bit per accepted transfer over a valid/ready interface tagged with the owner's ID. The block sits between the PN generator datapath and the consumers (scramblers, BIST pattern sources) that previously each instantiated their own generator.

## Interface
- LFSR_W, 3: LFSR width, legal range 3..16.
- TAPS, 3'b101: feedback tap mask; feedback = XOR of (lfsr & TAPS).
- SEED, all-ones: LFSR reset/reseed value; must be nonzero.
- LEN_W, 8: width of the burst-length inputs.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request level; held until the matching gnt bit is seen.
- len0  in  LEN_W  burst length in bits for requester 0; sampled at grant.
- len1  in  LEN_W  burst length in bits for requester 1; sampled at grant.
- gnt  out  2  one-hot, one-cycle grant pulse.
- pn_bit  out  1  current PN bit, equal to lfsr[0].
- pn_valid  out  1  pn_bit is valid.
- pn_ready  in  1  consumer accepts pn_bit.
- pn_last  out  1  current bit is the final bit of the burst.
- pn_id  out  1  owner of the current burst.
- busy  out  1  state is not IDLE.

## Operation
- State machine has two states: IDLE and RUN.
- Behaviour in IDLE with req != 0, at the clock edge:
  - Pick the winner. Round-robin pointer rr: if both requests are set, grant rr, otherwise grant the single requester.
  - Register gnt = onehot(winner), pn_id = winner, cnt = len of the winner, and rr = ~winner.
  - If the latched len != 0, go to RUN. If len == 0, pulse gnt, stay in IDLE, and emit no data.
- Behaviour in RUN:
  - pn_valid = 1 and pn_last = (cnt == 1).
  - On pn_valid & pn_ready, advance the LFSR: lfsr <= {fb, lfsr[LFSR_W-1:1]}, and decrement cnt.
  - If the accepted bit has pn_last set, go to IDLE.
- Backpressure: with pn_ready = 0, the LFSR, cnt, pn_bit and pn_last all hold.
- Requester rule: a requester must drop req in the cycle it sees gnt. A req still high in IDLE after its burst is treated as a new request.
- The LFSR only advances on accepted bits. It never passes through the all-zero state.
- Reset values: state = IDLE, lfsr = SEED (so pn_bit = SEED[0]), cnt = 0, gnt = 0, pn_valid = 0, pn_last = 0, pn_id = 0, rr = 0, busy = 0.
- Reset mid-burst: all state clears asynchronously to the values above. The partial burst is discarded and no pn_last is issued.

## Timing
- Grant latency: req seen in IDLE at edge N gives gnt high in cycle N+1. In the same cycle N+1, pn_valid is high with the first bit.
- gnt is high for exactly one cycle per grant, including len == 0 grants.
- Throughput: one bit per cycle while pn_ready = 1.
- A burst of L bits occupies L cycles of RUN with no stalls.
- Burst turnaround: at least one IDLE cycle between a pn_last acceptance and the next burst's first bit.
- pn_bit, pn_valid, pn_last and busy are driven from registers only. There is no combinational path from pn_ready to any output.
- req changes during RUN are ignored until the block returns to IDLE.

## Configuration
- PN_RESEED_EN defined: at every grant with len != 0, lfsr is reloaded with SEED. Every burst therefore starts with the same sequence, independent of history.
- PN_RESEED_EN undefined: the LFSR is free-continuing across bursts. Each burst resumes where the previous accepted bit left off.

## Test plan
- Single burst, defaults, PN_RESEED_EN off: req = 01, len0 = 7, pn_ready = 1. Expect gnt = 01 one cycle later, then pn_bit sequence 1,1,1,0,1,0,0 with pn_id = 0, pn_last on the 7th bit, then busy = 0.
- Round-robin: req = 11 held, lengths 2 and 3, each requester drops req on its gnt. Expect gnt = 01 first (rr = 0), the 2-bit burst, at least one IDLE cycle, then gnt = 10 and the 3-bit burst with pn_id = 1.
- Backpressure: len0 = 4, pn_ready toggling 1,0,0,1,1,0,1. Expect pn_bit and pn_last stable while stalled, and exactly 4 accepted bits 1,1,1,0.
- Zero length: req = 10, len1 = 0. Expect a single gnt = 10 pulse, pn_valid never asserted, lfsr unchanged, and rr = 0 afterwards.
- Reseed: with PN_RESEED_EN defined, run two back-to-back len0 = 3 bursts. Expect both to be 1,1,1. With it undefined, expect 1,1,1 then 0,1,0.
- Reset mid-burst: assert reset_n low during bit 3 of a 7-bit burst. Expect pn_valid = 0, busy = 0 and pn_bit = 1 immediately. A new burst after release starts at 1,1,1.
